// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: next-PC select, PC-register disable, redirect flushes, multdiv/halt freeze.
// Optional perf counters built only when PC_FETCH_PERF_EN is defined.
`default_nettype none

module pc_fetch_controller #(
   parameter int                ADDR_W       = 12,
   parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
   parameter int                FLUSH_CYCLES = 2,
   parameter int                MD_TIMEOUT   = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_current,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              hazard_stall,
   input  logic              md_start,
   input  logic              md_ready,
   input  logic              halt,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc_input,
   output logic              pc_dsble,
   output logic              flush_fd,
   output logic              flush_dx,
   output logic              md_error,
   output logic [1:0]        ctrl_state,
   output logic [15:0]       perf_stall,
   output logic [15:0]       perf_redirect
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      FLUSH   = 2'b01,
      MD_WAIT = 2'b10,
      HALT    = 2'b11
   } state_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] MD_LAST    = 8'(MD_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [2:0]  fcnt_q, fcnt_d;
   logic [7:0]  mdcnt_q, mdcnt_d;
   logic        err_q, err_d;
   logic        first_q;
   logic        flush;
   logic        redir_req;
   logic [ADDR_W-1:0] redir_tgt;
   logic [ADDR_W-1:0] pc_inc;

   assign redir_req = jump | branch_taken;
   assign redir_tgt = jump ? jump_target : branch_target;
   assign pc_inc    = pc_current + ADDR_W'(1);

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      mdcnt_d  = mdcnt_q;
      err_d    = err_q;
      pc_input = pc_current;
      pc_dsble = 1'b0;
      flush    = 1'b0;
      // Reset is asynchronous, so the outputs must also follow it combinationally.
      if (!reset) begin
         pc_input = RESET_VEC;
         pc_dsble = 1'b1;
      end else if (first_q) begin
         pc_input = RESET_VEC;
      end else begin
         unique case (state_q)
            RUN: begin
               if (halt) begin
                  pc_dsble = 1'b1;
                  state_d  = HALT;
               end else if (redir_req) begin
                  pc_input = redir_tgt;
                  flush    = 1'b1;
                  fcnt_d   = FLUSH_LOAD;
                  state_d  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               end else if (md_start) begin
                  pc_dsble = 1'b1;
                  mdcnt_d  = '0;
                  state_d  = MD_WAIT;
               end else if (hazard_stall) begin
                  pc_dsble = 1'b1;
               end else begin
                  pc_input = pc_inc;
               end
            end
            FLUSH: begin
               flush = 1'b1;
               if (redir_req) begin
                  pc_input = redir_tgt;
                  fcnt_d   = FLUSH_LOAD;
                  state_d  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               end else begin
                  pc_input = pc_inc;
                  fcnt_d   = fcnt_q - 3'd1;
                  if (fcnt_d == 3'd0) state_d = RUN;
               end
            end
            MD_WAIT: begin
               pc_dsble = 1'b1;
               if (md_ready) begin
                  state_d = RUN;
               end else if (mdcnt_q == MD_LAST) begin
                  err_d   = 1'b1;
                  state_d = RUN;
               end else begin
                  mdcnt_d = mdcnt_q + 8'd1;
               end
            end
            HALT: begin
               pc_dsble = 1'b1;
               if (resume && !halt) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         fcnt_q  <= '0;
         mdcnt_q <= '0;
         err_q   <= 1'b0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         mdcnt_q <= mdcnt_d;
         err_q   <= err_d;
         first_q <= 1'b0;
      end
   end

   assign flush_fd   = flush;
   assign flush_dx   = flush;
   assign md_error   = err_q;
   assign ctrl_state = state_q;

`ifdef PC_FETCH_PERF_EN
   logic [15:0] pstall_q, predir_q;
   logic        redirect;

   assign redirect = flush && redir_req;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pstall_q <= '0;
         predir_q <= '0;
      end else begin
         if (pc_dsble && (pstall_q != 16'hFFFF)) pstall_q <= pstall_q + 16'd1;
         if (redirect && (predir_q != 16'hFFFF)) predir_q <= predir_q + 16'd1;
      end
   end

   assign perf_stall    = pstall_q;
   assign perf_redirect = predir_q;
`else
   assign perf_stall    = 16'h0000;
   assign perf_redirect = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_controller.sv
// tb_pc_fetch_controller: directed plus random stimulus against a cycle-level behavioural model.
`default_nettype none

module tb_pc_fetch_controller;

   localparam int          ADDR_W       = 12;
   localparam logic [11:0] RESET_VEC    = 12'h000;
   localparam int          FLUSH_CYCLES = 2;
   localparam int          MD_TIMEOUT   = 32;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] pc_current = '0, branch_target = '0, jump_target = '0;
   logic        branch_taken = 0, jump = 0, hazard_stall = 0, md_start = 0;
   logic        md_ready = 0, halt = 0, resume = 0;
   logic [11:0] pc_input;
   logic        pc_dsble, flush_fd, flush_dx, md_error;
   logic [1:0]  ctrl_state;
   logic [15:0] perf_stall, perf_redirect;

   pc_fetch_controller #(
      .ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC),
      .FLUSH_CYCLES(FLUSH_CYCLES), .MD_TIMEOUT(MD_TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset), .pc_current(pc_current),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .hazard_stall(hazard_stall),
      .md_start(md_start), .md_ready(md_ready), .halt(halt), .resume(resume),
      .pc_input(pc_input), .pc_dsble(pc_dsble), .flush_fd(flush_fd),
      .flush_dx(flush_dx), .md_error(md_error), .ctrl_state(ctrl_state),
      .perf_stall(perf_stall), .perf_redirect(perf_redirect)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Model: mode 0 run, 1 flush, 2 multdiv wait, 3 halted.
   int          m_mode, m_flush_left, m_md_age, m_pstall, m_predir;
   bit          m_err, m_first;
   logic [11:0] pc_reg = '0;
   logic [11:0] e_pc;
   bit          e_dsble, e_flush, e_redir;

   logic [11:0] o_pc;
   logic [1:0]  o_state;
   logic        o_dsble, o_flush, o_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_flush_left = 0; m_md_age = 0;
      m_err = 0; m_first = 1; m_pstall = 0; m_predir = 0;
   endtask

   task automatic model_outputs();
      e_pc = pc_current; e_dsble = 0; e_flush = 0; e_redir = 0;
      if (!reset) begin
         e_pc = RESET_VEC; e_dsble = 1;
      end else if (m_first) begin
         e_pc = RESET_VEC;
      end else if (m_mode == 0 && halt) begin
         e_dsble = 1;
      end else if ((m_mode == 0 || m_mode == 1) && (jump || branch_taken)) begin
         e_redir = 1; e_flush = 1;
         e_pc = jump ? jump_target : branch_target;
      end else if (m_mode == 0 && (md_start || hazard_stall)) begin
         e_dsble = 1;
      end else if (m_mode == 0 || m_mode == 1) begin
         e_flush = (m_mode == 1);
         e_pc = 12'(pc_current + 12'd1);
      end else begin
         e_dsble = 1;
      end
   endtask

   task automatic model_advance();
      if (!reset) begin
         model_reset();
         return;
      end
      if (e_dsble && m_pstall < 65535) m_pstall++;
      if (e_redir && m_predir < 65535) m_predir++;
      if (m_first) begin
         m_first = 0;
      end else if (m_mode == 0) begin
         if (halt) m_mode = 3;
         else if (e_redir) begin
            m_flush_left = FLUSH_CYCLES - 1;
            m_mode = (m_flush_left > 0) ? 1 : 0;
         end else if (md_start) begin
            m_mode = 2; m_md_age = 0;
         end
      end else if (m_mode == 1) begin
         m_flush_left = e_redir ? FLUSH_CYCLES - 1 : m_flush_left - 1;
         if (m_flush_left == 0) m_mode = 0;
      end else if (m_mode == 2) begin
         m_md_age++;
         if (md_ready) m_mode = 0;
         else if (m_md_age == MD_TIMEOUT) begin
            m_err = 1; m_mode = 0;
         end
      end else if (resume && !halt) begin
         m_mode = 0;
      end
   endtask

   task automatic step();
      pc_current = pc_reg;
      if (!reset) model_reset();
      model_outputs();
      @(negedge clock);
      o_pc = pc_input; o_state = ctrl_state; o_dsble = pc_dsble;
      o_flush = flush_fd; o_err = md_error;
      check("state", {30'd0, ctrl_state}, m_mode);
      check("dsble", {31'd0, pc_dsble}, {31'd0, e_dsble});
      check("flush_fd", {31'd0, flush_fd}, {31'd0, e_flush});
      check("flush_dx", {31'd0, flush_dx}, {31'd0, e_flush});
      check("md_error", {31'd0, md_error}, {31'd0, m_err});
      if (!e_dsble || !reset) check("pc_input", {20'd0, pc_input}, {20'd0, e_pc});
`ifdef PC_FETCH_PERF_EN
      check("perf_stall", {16'd0, perf_stall}, m_pstall);
      check("perf_redirect", {16'd0, perf_redirect}, m_predir);
`else
      check("perf_off", {perf_stall, perf_redirect}, 32'd0);
`endif
      @(posedge clock);
      model_advance();
      if (!e_dsble) pc_reg = e_pc;
      #1;
   endtask

   task automatic clr();
      branch_taken = 0; jump = 0; hazard_stall = 0; md_start = 0;
      md_ready = 0; halt = 0; resume = 0;
   endtask

   initial begin
      model_reset();
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_pc", {20'd0, o_pc}, 32'h000);
         check("rst_dsble", {31'd0, o_dsble}, 32'd1);
      end
      reset = 1;
      step();
      check("first_dsble", {31'd0, o_dsble}, 32'd0);
      check("first_pc", {20'd0, o_pc}, 32'h000);
      step();
      check("inc_pc", {20'd0, o_pc}, 32'h001);

      pc_reg = 12'hFFF;
      step();
      check("wrap_pc", {20'd0, o_pc}, 32'h000);

      jump = 1; jump_target = 12'h040; branch_taken = 1; branch_target = 12'h080;
      step();
      check("jmp_pc", {20'd0, o_pc}, 32'h040);
      check("jmp_flush0", {31'd0, o_flush}, 32'd1);
      clr();
      step();
      check("jmp_state1", {30'd0, o_state}, 32'd1);
      check("jmp_flush1", {31'd0, o_flush}, 32'd1);
      step();
      check("jmp_state2", {30'd0, o_state}, 32'd0);
      check("jmp_flush2", {31'd0, o_flush}, 32'd0);

      md_start = 1; step(); clr();
      for (int i = 1; i <= 5; i++) begin
         branch_taken = (i == 3); branch_target = 12'h300; md_ready = (i == 5);
         step();
         check("md_dsble", {31'd0, o_dsble}, 32'd1);
         check("md_state", {30'd0, o_state}, 32'd2);
      end
      clr(); step();
      check("md_back_run", {30'd0, o_state}, 32'd0);
      check("md_no_err", {31'd0, o_err}, 32'd0);

      md_start = 1; step(); clr();
      for (int i = 0; i < MD_TIMEOUT; i++) begin
         halt = (i == 4);
         step();
         check("to_wait", {30'd0, o_state}, 32'd2);
      end
      halt = 0; step();
      check("to_run", {30'd0, o_state}, 32'd0);
      check("to_err", {31'd0, o_err}, 32'd1);
      step(); step();
      check("to_sticky", {31'd0, o_err}, 32'd1);

      md_start = 1; step(); clr(); step(); step();
      reset = 0; step();
      check("rst_mid_err", {31'd0, o_err}, 32'd0);
      check("rst_mid_state", {30'd0, o_state}, 32'd0);
      reset = 1; step();

      halt = 1; step(); step();
      check("halt_state", {30'd0, o_state}, 32'd3);
      resume = 1; step();
      halt = 0; step();
      clr(); step();
      check("resume_run", {30'd0, o_state}, 32'd0);

      for (int i = 0; i < 600; i++) begin
         reset        = ($urandom_range(0, 149) != 0);
         halt         = ($urandom_range(0, 19) == 0);
         resume       = ($urandom_range(0, 3) == 0);
         jump         = ($urandom_range(0, 9) == 0);
         branch_taken = ($urandom_range(0, 7) == 0);
         hazard_stall = ($urandom_range(0, 7) == 0);
         md_start     = ($urandom_range(0, 9) == 0);
         md_ready     = ($urandom_range(0, 11) == 0);
         jump_target   = 12'($urandom);
         branch_target = 12'($urandom);
         if ($urandom_range(0, 31) == 0) pc_reg = 12'($urandom);
         step();
      end
      clr(); reset = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
Sequences the 12-bit program counter register each cycle. It selects the next PC (increment, branch, jump, or hold), drives the register's disable input, and generates pipeline flushes after redirects. It also freezes fetch for multdiv operations and halts. It sits between the execute-stage branch/jump resolution, the hazard unit and the pc register.

Parameters:
ADDR_W, 12, PC width
RESET_VEC, 12'h000, next-PC value driven while in reset and on the first cycle after it
FLUSH_CYCLES, 2, number of cycles flush_fd/flush_dx stay asserted after a redirect (1..7)
MD_TIMEOUT, 32, maximum MD_WAIT cycles before forced exit (2..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_current  in  ADDR_W  present pc register output
branch_taken  in  1  execute-stage branch resolved taken
branch_target  in  ADDR_W  branch destination
jump  in  1  execute-stage jump/jal/jr
jump_target  in  ADDR_W  jump destination
hazard_stall  in  1  load-use stall from hazard unit, single cycle
md_start  in  1  multdiv operation issued
md_ready  in  1  multdiv result valid
halt  in  1  halt request
resume  in  1  leave HALT
pc_input  out  ADDR_W  next PC to the pc register
pc_dsble  out  1  disable to the pc register
flush_fd  out  1  flush F/D latch
flush_dx  out  1  flush D/X latch
md_error  out  1  sticky multdiv timeout flag
ctrl_state  out  2  encoded FSM state
perf_stall  out  16  stall-cycle counter (optional feature)
perf_redirect  out  16  redirect counter (optional feature)

Behaviour:
- Reset asserted (reset=0), at any time including mid-FLUSH or mid-MD_WAIT, forces:
  - state RUN, flush counter 0, MD counter 0, md_error=0;
  - pc_input=RESET_VEC, pc_dsble=1, flush_fd=flush_dx=0;
  - perf counters 0.
- First cycle after reset release: pc_input=RESET_VEC, pc_dsble=0.
- States: RUN=2'b00, FLUSH=2'b01, MD_WAIT=2'b10, HALT=2'b11.
- pc_input and pc_dsble are combinational from the registered state plus current inputs. State changes on the rising clock edge.
- RUN, highest priority first:
  - halt: pc_dsble=1, next state HALT.
  - jump: pc_input=jump_target, flush_fd=flush_dx=1, next state FLUSH with count=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
  - branch_taken: same as jump, using branch_target. Jump wins when both are asserted.
  - md_start: pc_dsble=1, MD counter cleared, next state MD_WAIT.
  - hazard_stall: pc_dsble=1, state stays RUN.
  - otherwise: pc_input=pc_current+1, modulo 2^ADDR_W (12'hFFF wraps to 12'h000), pc_dsble=0.
- FLUSH:
  - flush_fd=flush_dx=1 and PC increments.
  - Count decrements; leave to RUN when the count is 0.
  - A new jump or branch_taken reloads the count and redirects.
  - halt and md_start are ignored while in FLUSH.
- MD_WAIT:
  - pc_dsble=1; branch, jump and hazard inputs are ignored.
  - md_ready: next state RUN, and PC increments on the following RUN cycle.
  - MD counter reaches MD_TIMEOUT-1 without md_ready: set md_error (sticky until reset), next state RUN.
  - md_ready on the timeout cycle: md_ready wins and md_error is not set.
- HALT:
  - pc_dsble=1.
  - resume: next state RUN.
  - halt and resume asserted together: stay in HALT.
- flush_fd and flush_dx are 0 in every state except as stated above.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - perf_stall increments on every clock with pc_dsble=1 and reset high.
  - perf_redirect increments on each accepted jump or branch redirect.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset held 0 for 3 cycles, then released: pc_input=12'h000 and pc_dsble=1 during reset; pc_dsble=0 on the first released cycle; pc_current=12'h000 then yields pc_input=12'h001.
- pc_current=12'hFFF, no events: pc_input=12'h000 (wrap).
- jump=1 with jump_target=12'h040 and branch_taken=1 with branch_target=12'h080 in the same cycle: pc_input=12'h040; flush_fd=flush_dx=1 for exactly 2 cycles; ctrl_state 00→01→00.
- md_start, then md_ready 5 cycles later: pc_dsble=1 for the 5 wait cycles; a branch_taken pulse mid-wait is ignored; returns to RUN with md_error=0.
- md_start with md_ready never asserted: after 32 cycles md_error=1 and the FSM is in RUN; md_error holds until reset=0.
- halt during MD_WAIT is ignored. Later, from RUN, halt gives ctrl_state=11; resume+halt together keeps HALT; resume alone returns to RUN. With PC_FETCH_PERF_EN defined, perf_stall equals the total dsble cycles.
